// File: rtl/alu_control_unit.sv
// Multicycle control unit in front of the 32-bit ALU: fetches operands from a small register
// file, drives the ALU for ALU_LAT cycles, then writes the result and C/Z/N flags back.
module alu_control_unit #(
  parameter int WIDTH   = 32,
  parameter int NREG    = 8,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr_in,
  output logic [5:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_ans1,
  input  logic [WIDTH-1:0] alu_ans2,
  input  logic             alu_z,
  input  logic             alu_n,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [2:0]       flags,
  input  logic [2:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB
  } state_t;

  state_t           r_state;
  logic             r_ready;
  logic [31:0]      r_instr;
  logic [WIDTH-1:0] r_regs [NREG];
  logic [CW-1:0]    r_latCnt;
  logic [5:0]       r_aluOpcode;
  logic [WIDTH-1:0] r_aluA;
  logic [WIDTH-1:0] r_aluB;
  logic             r_aluCin;
  logic [WIDTH-1:0] r_result;
  logic             r_capC;
  logic             r_capZ;
  logic             r_capN;
  logic             r_done;
  logic             r_err;
  logic [2:0]       r_flags;

  logic [5:0]       w_op;
  logic [2:0]       w_rd;
  logic [2:0]       w_rs1;
  logic [2:0]       w_rs2;
  logic             w_useImm;
  logic             w_useCarry;
  logic [14:0]      w_imm;
  logic [WIDTH-1:0] w_sext;
  logic             w_legal;
  logic             w_isAddSub;
  logic             w_unused_ans2;

  assign w_op       = r_instr[31:26];
  assign w_rd       = r_instr[25:23];
  assign w_rs1      = r_instr[22:20];
  assign w_rs2      = r_instr[19:17];
  assign w_useImm   = r_instr[16];
  assign w_useCarry = r_instr[15];
  assign w_imm      = r_instr[14:0];
  assign w_sext     = {{(WIDTH-15){w_imm[14]}}, w_imm};
  assign w_legal    = (w_op >= 6'h01) && (w_op <= 6'h09);
  assign w_isAddSub = (w_op == 6'h01) || (w_op == 6'h02);
  // Only the carry/borrow bit of the secondary result is consumed.
  assign w_unused_ans2 = ^alu_ans2[WIDTH-1:1];

  assign instr_ready = r_ready;
  assign alu_opcode  = r_aluOpcode;
  assign alu_a       = r_aluA;
  assign alu_b       = r_aluB;
  assign alu_cin     = r_aluCin;
  assign done        = r_done;
  assign result      = r_result;
  assign err         = r_err;
  assign flags       = r_flags;
  assign dbg_data    = (dbg_addr == 3'd0) ? '0 : r_regs[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b1;
      r_instr     <= '0;
      r_latCnt    <= '0;
      r_aluOpcode <= '0;
      r_aluA      <= '0;
      r_aluB      <= '0;
      r_aluCin    <= 1'b0;
      r_result    <= '0;
      r_capC      <= 1'b0;
      r_capZ      <= 1'b0;
      r_capN      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_flags     <= '0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_instr <= instr_in;
            r_ready <= 1'b0;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          // R0 is never written, so a plain array read already returns zero for it.
          r_aluOpcode <= w_op;
          r_aluA      <= r_regs[w_rs1];
          r_aluB      <= w_useImm ? w_sext : r_regs[w_rs2];
          r_aluCin    <= w_useCarry & r_flags[2];
          r_latCnt    <= '0;
          r_state     <= S_EXEC;
        end
        S_EXEC: begin
          if (r_latCnt == CW'(ALU_LAT - 1)) begin
            r_result <= alu_ans1;
            r_capC   <= alu_ans2[0];
            r_capZ   <= alu_z;
            r_capN   <= alu_n;
            r_done   <= 1'b1;
            r_err    <= ~w_legal;
            r_state  <= S_WB;
          end else begin
            r_latCnt <= r_latCnt + CW'(1);
          end
        end
        S_WB: begin
          if (w_legal) begin
            if (w_rd != 3'd0) r_regs[w_rd] <= r_result;
            r_flags[1] <= r_capZ;
            r_flags[0] <= r_capN;
            if (w_isAddSub) r_flags[2] <= r_capC;
          end
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_unit.sv
// Bench for alu_control_unit: a behavioural ALU answers each DUT, a vector table drives the
// main instruction mix, and hand-written sequences cover reset and back-to-back throughput.
module tb_alu_control_unit;

  typedef struct packed {
    logic [31:0] ans1;
    logic [31:0] ans2;
    logic        z;
    logic        n;
  } aluOut_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] expA;
    logic [31:0] expB;
    logic        expCin;
    logic [31:0] expResult;
    logic        expErr;
    logic [2:0]  expFlags;
    logic [2:0]  dbgAddr;
    logic [31:0] expDbg;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        instrValid = 1'b0;
  logic        instrReady;
  logic [31:0] instrIn = '0;
  logic [5:0]  aluOpcode;
  logic [31:0] aluA, aluB, aluAns1, aluAns2;
  logic        aluCin, aluZ, aluN;
  logic        done, err;
  logic [31:0] result, dbgData;
  logic [2:0]  flags;
  logic [2:0]  dbgAddr = '0;

  logic        instrValid3 = 1'b0;
  logic        instrReady3;
  logic [31:0] instrIn3 = '0;
  logic [5:0]  aluOpcode3;
  logic [31:0] aluA3, aluB3, aluAns13, aluAns23;
  logic        aluCin3, aluZ3, aluN3;
  logic        done3, err3;
  logic [31:0] result3, dbgData3;
  logic [2:0]  flags3;
  logic [2:0]  dbgAddr3 = '0;

  aluOut_t     m1, m3;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        recordEn = 1'b0;
  int          acc1 [8];
  int          acc3 [8];
  int          n1 = 0;
  int          n3 = 0;
  int          done3Cyc = -1;
  vec_t        vecs [11];

  always #5 clk = ~clk;

  alu_control_unit #(.WIDTH(32), .NREG(8), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instrValid), .instr_ready(instrReady),
    .instr_in(instrIn), .alu_opcode(aluOpcode), .alu_a(aluA), .alu_b(aluB), .alu_cin(aluCin),
    .alu_ans1(aluAns1), .alu_ans2(aluAns2), .alu_z(aluZ), .alu_n(aluN), .done(done),
    .result(result), .err(err), .flags(flags), .dbg_addr(dbgAddr), .dbg_data(dbgData)
  );

  alu_control_unit #(.WIDTH(32), .NREG(8), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instrValid3), .instr_ready(instrReady3),
    .instr_in(instrIn3), .alu_opcode(aluOpcode3), .alu_a(aluA3), .alu_b(aluB3), .alu_cin(aluCin3),
    .alu_ans1(aluAns13), .alu_ans2(aluAns23), .alu_z(aluZ3), .alu_n(aluN3), .done(done3),
    .result(result3), .err(err3), .flags(flags3), .dbg_addr(dbgAddr3), .dbg_data(dbgData3)
  );

  function automatic aluOut_t aluModel(input logic [5:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic cin);
    aluOut_t     o;
    logic [32:0] t;
    o = '0;
    t = '0;
    case (op)
      6'h01: begin t = {1'b0, a} + {1'b0, b} + {32'b0, cin}; o.ans1 = t[31:0]; o.ans2 = {31'b0, t[32]}; end
      6'h02: begin t = {1'b0, a} - {1'b0, b} - {32'b0, cin}; o.ans1 = t[31:0]; o.ans2 = {31'b0, t[32]}; end
      6'h03: o.ans1 = {31'b0, a == b};
      6'h04: o.ans1 = {31'b0, a != b};
      6'h05: o.ans1 = {31'b0, $signed(a) <= $signed(b)};
      6'h06: o.ans1 = {31'b0, $signed(a) > $signed(b)};
      6'h07: o.ans1 = a << b[4:0];
      6'h08: o.ans1 = a >> b[4:0];
      6'h09: o.ans1 = $unsigned($signed(a) >>> b[4:0]);
      default: o.ans1 = 32'hDEADBEEF;
    endcase
    o.z = (o.ans1 == 32'h0);
    o.n = o.ans1[31];
    return o;
  endfunction

  always_comb m1 = aluModel(aluOpcode, aluA, aluB, aluCin);
  always_comb m3 = aluModel(aluOpcode3, aluA3, aluB3, aluCin3);
  assign aluAns1  = m1.ans1;
  assign aluAns2  = m1.ans2;
  assign aluZ     = m1.z;
  assign aluN     = m1.n;
  assign aluAns13 = m3.ans1;
  assign aluAns23 = m3.ans2;
  assign aluZ3    = m3.z;
  assign aluN3    = m3.n;

  // Accept and done-rise edges are logged only while the throughput sequence is running.
  always @(posedge clk) begin
    if (recordEn) begin
      if (instrValid && instrReady && n1 < 8) begin acc1[n1] <= cyc; n1 <= n1 + 1; end
      if (instrValid3 && instrReady3 && n3 < 8) begin acc3[n3] <= cyc; n3 <= n3 + 1; end
      if (done3 && done3Cyc < 0) done3Cyc <= cyc;
    end
    cyc <= cyc + 1;
  end

  function automatic logic [31:0] mkInstr(input logic [5:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs1, input logic [2:0] rs2,
                                          input logic useImm, input logic useCarry,
                                          input logic [14:0] imm);
    return {op, rd, rs1, rs2, useImm, useCarry, imm};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] instr, output int latency);
    int k;
    k = 0;
    while (!instrReady && k < 20) begin @(negedge clk); k++; end
    checkOutput("readyBeforeIssue", {31'b0, instrReady}, 32'h1);
    instrValid = 1'b1;
    instrIn    = instr;
    @(posedge clk);
    @(negedge clk);
    instrValid = 1'b0;
    latency = 1;
    while (!done && latency < 20) begin @(negedge clk); latency++; end
    if (!done) latency = -1;
  endtask

  initial begin
    int lat;
    int k;
    logic sawDone;

    vecs[0]  = '{mkInstr(6'h01, 3'd1, 3'd0, 3'd0, 1'b1, 1'b0, 15'd1),  32'h0, 32'h1, 1'b0, 32'h1, 1'b0, 3'b000, 3'd1, 32'h1};
    vecs[1]  = '{mkInstr(6'h07, 3'd1, 3'd1, 3'd0, 1'b1, 1'b0, 15'd16), 32'h1, 32'h10, 1'b0, 32'h00010000, 1'b0, 3'b000, 3'd1, 32'h00010000};
    vecs[2]  = '{mkInstr(6'h01, 3'd2, 3'd1, 3'd0, 1'b1, 1'b0, 15'd1),  32'h00010000, 32'h1, 1'b0, 32'h00010001, 1'b0, 3'b000, 3'd2, 32'h00010001};
    vecs[3]  = '{mkInstr(6'h02, 3'd3, 3'd2, 3'd2, 1'b0, 1'b0, 15'd0),  32'h00010001, 32'h00010001, 1'b0, 32'h0, 1'b0, 3'b010, 3'd3, 32'h0};
    vecs[4]  = '{mkInstr(6'h01, 3'd4, 3'd3, 3'd0, 1'b1, 1'b0, 15'd5),  32'h0, 32'h5, 1'b0, 32'h5, 1'b0, 3'b000, 3'd4, 32'h5};
    vecs[5]  = '{mkInstr(6'h31, 3'd5, 3'd4, 3'd0, 1'b1, 1'b0, 15'd7),  32'h5, 32'h7, 1'b0, 32'hDEADBEEF, 1'b1, 3'b000, 3'd5, 32'h0};
    vecs[6]  = '{mkInstr(6'h02, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 15'd1),  32'h0, 32'h1, 1'b0, 32'hFFFFFFFF, 1'b0, 3'b101, 3'd0, 32'h0};
    vecs[7]  = '{mkInstr(6'h01, 3'd6, 3'd4, 3'd0, 1'b1, 1'b1, 15'd2),  32'h5, 32'h2, 1'b1, 32'h8, 1'b0, 3'b000, 3'd6, 32'h8};
    vecs[8]  = '{mkInstr(6'h01, 3'd7, 3'd0, 3'd0, 1'b1, 1'b0, 15'h7FFF), 32'h0, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0, 3'b001, 3'd7, 32'hFFFFFFFF};
    vecs[9]  = '{mkInstr(6'h09, 3'd7, 3'd7, 3'd0, 1'b1, 1'b0, 15'd4),  32'hFFFFFFFF, 32'h4, 1'b0, 32'hFFFFFFFF, 1'b0, 3'b001, 3'd7, 32'hFFFFFFFF};
    vecs[10] = '{mkInstr(6'h03, 3'd5, 3'd4, 3'd4, 1'b0, 1'b0, 15'd0),  32'h5, 32'h5, 1'b0, 32'h1, 1'b0, 3'b000, 3'd5, 32'h1};

    repeat (3) @(negedge clk);
    dbgAddr = 3'd1;
    rst_n   = 1'b1;
    @(negedge clk);
    checkOutput("resetReady",  {31'b0, instrReady}, 32'h1);
    checkOutput("resetFlags",  {29'b0, flags}, 32'h0);
    checkOutput("resetDone",   {31'b0, done}, 32'h0);
    checkOutput("resetErr",    {31'b0, err}, 32'h0);
    checkOutput("resetResult", result, 32'h0);
    checkOutput("resetAluA",   aluA, 32'h0);
    checkOutput("resetDbg",    dbgData, 32'h0);

    for (int i = 0; i < 11; i++) begin
      dbgAddr = vecs[i].dbgAddr;
      applyStimulus(vecs[i].instr, lat);
      checkOutput($sformatf("v%0d latency", i), 32'(lat), 32'd3);
      checkOutput($sformatf("v%0d aluOpcode", i), {26'b0, aluOpcode}, {26'b0, vecs[i].instr[31:26]});
      checkOutput($sformatf("v%0d aluA", i), aluA, vecs[i].expA);
      checkOutput($sformatf("v%0d aluB", i), aluB, vecs[i].expB);
      checkOutput($sformatf("v%0d aluCin", i), {31'b0, aluCin}, {31'b0, vecs[i].expCin});
      checkOutput($sformatf("v%0d result", i), result, vecs[i].expResult);
      checkOutput($sformatf("v%0d err", i), {31'b0, err}, {31'b0, vecs[i].expErr});
      @(negedge clk);
      checkOutput($sformatf("v%0d donePulse", i), {31'b0, done}, 32'h0);
      checkOutput($sformatf("v%0d flags", i), {29'b0, flags}, {29'b0, vecs[i].expFlags});
      checkOutput($sformatf("v%0d dbgData", i), dbgData, vecs[i].expDbg);
    end

    // Reset pulse while an instruction sits in EXEC must abandon it without a writeback.
    applyStimulus(mkInstr(6'h02, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 15'd1), lat);
    @(negedge clk);
    checkOutput("preResetFlags", {29'b0, flags}, 32'h5);
    dbgAddr    = 3'd6;
    instrValid = 1'b1;
    instrIn    = mkInstr(6'h01, 3'd6, 3'd4, 3'd0, 1'b1, 1'b0, 15'd100);
    @(posedge clk);
    @(negedge clk);
    instrValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midExecResetReady", {31'b0, instrReady}, 32'h1);
    checkOutput("midExecResetFlags", {29'b0, flags}, 32'h0);
    checkOutput("midExecResetAluA",  aluA, 32'h0);
    sawDone = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    checkOutput("midExecNoDone", {31'b0, sawDone}, 32'h0);
    checkOutput("midExecNoWrite", dbgData, 32'h0);

    // Valid held high on both units: accepts must be spaced ALU_LAT+3 cycles apart.
    recordEn    = 1'b1;
    instrValid  = 1'b1;
    instrIn     = mkInstr(6'h01, 3'd1, 3'd1, 3'd0, 1'b1, 1'b0, 15'd1);
    instrValid3 = 1'b1;
    instrIn3    = mkInstr(6'h01, 3'd1, 3'd1, 3'd0, 1'b1, 1'b0, 15'd1);
    k = 0;
    while ((n1 < 3 || n3 < 3) && k < 40) begin @(negedge clk); k++; end
    instrValid  = 1'b0;
    instrValid3 = 1'b0;
    recordEn    = 1'b0;
    checkOutput("tputAccepts1", {31'b0, n1 >= 3}, 32'h1);
    checkOutput("tputAccepts3", {31'b0, n3 >= 3}, 32'h1);
    if (n1 >= 3) begin
      checkOutput("tputSpacing1a", 32'(acc1[1] - acc1[0]), 32'd4);
      checkOutput("tputSpacing1b", 32'(acc1[2] - acc1[1]), 32'd4);
    end
    if (n3 >= 3) begin
      checkOutput("tputSpacing3a", 32'(acc3[1] - acc3[0]), 32'd6);
      checkOutput("tputSpacing3b", 32'(acc3[2] - acc3[1]), 32'd6);
      checkOutput("latency3", 32'(done3Cyc - acc3[0]), 32'd5);
    end
    repeat (8) @(negedge clk);
    dbgAddr3 = 3'd1;
    #1;
    checkOutput("tputDbg3", dbgData3, 32'(n3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
